jk_bank_sequencer: RTL
======================

# jk_bank_sequencer

Command sequencer for a bank of WIDTH master-slave JK flip-flops (one JK cell per bit, master captures on posedge, slave transfers on negedge). It accepts hold/clear/set/toggle commands with a per-bit mask over a valid/ready handshake, drives the bank's J/K inputs for exactly one clock, waits for the slave stage to settle, then reads the bank back. It checks the readback against an internal shadow model and returns the observed value and a mismatch flag on a valid/ready response channel. It sits between the register-control logic and the JK bank and owns the bank's reset.

## Interface
- WIDTH, 8: number of JK cells in the bank; legal 1..32.
- SETTLE, 2: idle cycles (J=K=0) between drive and readback; legal 1..15.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a posedge.
- cmd_op  in  2  00 hold, 01 clear, 10 set, 11 toggle.
- cmd_mask  in  WIDTH  bits affected by cmd_op.
- j_out  out  WIDTH  registered J drive to the bank.
- k_out  out  WIDTH  registered K drive to the bank.
- bank_rst_n  out  1  registered active-low reset to the bank.
- q_in  in  WIDTH  bank slave outputs.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a posedge.
- rsp_q  out  WIDTH  q_in sampled in CHECK.
- rsp_err  out  1  sampled q differs from shadow expectation.
- busy  out  1  state other than IDLE.

## Operation
- States: INIT, IDLE, DRIVE, SETTLE, CHECK, RESP.
- Reset values: state INIT; j_out=k_out=0; bank_rst_n=0; cmd_ready=0; rsp_valid=0; rsp_q=0; rsp_err=0; busy=1; shadow exp=0; settle counter=0.
- INIT: lasts exactly one cycle after rst deasserts. bank_rst_n stays 0 through this cycle and goes 1 on entry to IDLE.
- IDLE: cmd_ready=1. On accept, latch op and mask, go to DRIVE.
- Drive vectors (masked bits only; unmasked bits J=K=0):
  - hold: J=0, K=0
  - clear: J=0, K=1
  - set: J=1, K=0
  - toggle: J=1, K=1
- Expected next value:
  - hold: exp
  - clear: exp & ~mask
  - set: exp | mask
  - toggle: exp ^ mask
- DRIVE: j_out/k_out hold the vectors for exactly one cycle, so the bank sees exactly one capturing posedge and each toggled bit flips once. Then go to SETTLE with j_out=k_out=0.
- SETTLE: count SETTLE cycles with J=K=0, then go to CHECK.
- CHECK: sample q_in into rsp_q. Set rsp_err = (q_in != expected).
  - exp := q_in in both cases, so the model resynchronises after a fault.
  - Go to RESP.
- RESP: rsp_valid=1. rsp_q and rsp_err are held stable until rsp_ready, then go to IDLE.
- cmd_ready is 0 in every state except IDLE, so commands are never accepted while a response is pending.
- rst asserted in any state, including mid-SETTLE or during RESP, returns every output and exp to reset values at that edge. Any in-flight command and response are discarded.

## Timing
- Command accepted at edge T:
  - j_out/k_out valid during cycle T..T+1; the bank master captures at edge T+1.
  - J=K=0 from edge T+1.
  - CHECK occupies the cycle after SETTLE completes.
  - rsp_valid rises at edge T+SETTLE+2, i.e. accept-to-response latency is SETTLE+2 cycles (4 for SETTLE=2).
- Response handshake at edge R leads to IDLE. Earliest next accept is edge R+1, so there is no same-edge response/command overlap.
- Maximum throughput: one command per SETTLE+4 cycles with rsp_ready tied high.
- rsp_q, rsp_err, j_out, k_out, bank_rst_n and cmd_ready are all registered; no combinational input-to-output path.

## Test plan
- Reset, WIDTH=8, SETTLE=2: hold rst high for 3 cycles, then release.
  - While rst is high and in INIT: j_out=k_out=0x00, bank_rst_n=0, cmd_ready=0, rsp_valid=0.
  - bank_rst_n=1 and cmd_ready=1 on the second cycle after release.
- Set, mask 0xF0, bank at 0x00:
  - j_out=0xF0, k_out=0x00 for exactly one cycle.
  - rsp_valid 4 cycles after accept, rsp_q=0xF0, rsp_err=0.
- Sequence starting from 0xF0:
  - toggle 0x3C → rsp_q=0xCC.
  - clear 0x0F → rsp_q=0xC0.
  - hold 0xFF → j_out=k_out=0x00, rsp_q=0xC0.
  - All rsp_err=0.
- Fault: force q_in[0] stuck at 0, then set 0x01.
  - rsp_err=1, rsp_q=0x00.
  - A following hold returns rsp_err=0 (exp resynchronised).
- Backpressure: hold rsp_ready low for 10 cycles with cmd_valid high.
  - rsp_valid, rsp_q and rsp_err stay stable; cmd_ready=0 throughout; no command accepted.
  - Exactly one accept after rsp_ready pulses.
- Reset mid-operation: assert rst during the second SETTLE cycle.
  - All outputs take reset values at the next edge and no response appears.
  - After INIT, a set of 0x01 reports rsp_q=0x01, rsp_err=0 (exp reset to 0).

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command sequencer that drives, settles and verifies a master-slave JK bank
module jk_bank_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             bank_rst_n,
  input  logic [WIDTH-1:0] q_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state, state_nx;
  logic [1:0]       op, op_nx;
  logic [WIDTH-1:0] mask, mask_nx;
  logic [WIDTH-1:0] exp_q, exp_nx;
  logic [WIDTH-1:0] exp_target;
  logic [WIDTH-1:0] j_nx, k_nx;
  logic [WIDTH-1:0] rsp_q_nx;
  logic             rsp_err_nx;
  logic [3:0]       cnt, cnt_nx;

  // Shadow model: value the bank should hold after the latched command lands.
  always_comb begin
    exp_target = exp_q;
    case (op)
      OP_HOLD:  exp_target = exp_q;
      OP_CLEAR: exp_target = exp_q & ~mask;
      OP_SET:   exp_target = exp_q | mask;
      default:  exp_target = exp_q ^ mask;
    endcase
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nx   = state;
    op_nx      = op;
    mask_nx    = mask;
    exp_nx     = exp_q;
    cnt_nx     = cnt;
    j_nx       = '0;
    k_nx       = '0;
    rsp_q_nx   = rsp_q;
    rsp_err_nx = rsp_err;
    case (state)
      S_INIT: state_nx = S_IDLE;
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_nx    = cmd_op;
          mask_nx  = cmd_mask;
          // J is asserted for set/toggle, K for clear/toggle, only on masked bits.
          j_nx     = cmd_op[1] ? cmd_mask : '0;
          k_nx     = cmd_op[0] ? cmd_mask : '0;
          state_nx = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_nx   = '0;
        state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nx = S_CHECK;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_CHECK: begin
        rsp_q_nx   = q_in;
        rsp_err_nx = (q_in != exp_target);
        // Resynchronise to what the bank really holds so one fault reports once.
        exp_nx     = q_in;
        state_nx   = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  // State and registered outputs; reset discards any in-flight command or response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      op         <= OP_HOLD;
      mask       <= '0;
      exp_q      <= '0;
      cnt        <= '0;
      j_out      <= '0;
      k_out      <= '0;
      bank_rst_n <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_q      <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      op         <= op_nx;
      mask       <= mask_nx;
      exp_q      <= exp_nx;
      cnt        <= cnt_nx;
      j_out      <= j_nx;
      k_out      <= k_nx;
      bank_rst_n <= (state_nx != S_INIT);
      cmd_ready  <= (state_nx == S_IDLE);
      rsp_valid  <= (state_nx == S_RESP);
      rsp_q      <= rsp_q_nx;
      rsp_err    <= rsp_err_nx;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
